// File: rtl/fp_simd_pkg.sv
// Shared types for the FP SIMD ALU command path: lane geometry, opcodes and issuer states.
package fp_simd_pkg;

  localparam int FP_W       = 22;
  localparam int SIMD_LANES = 4;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_RCP  = 3'd3,
    OP_RADD = 3'd4,
    OP_RMUL = 3'd5
  } op_e;

  localparam logic [2:0] OP_LEGAL_MAX = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } iss_state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_LEGAL_MAX);
  endfunction

endpackage

// File: rtl/simd_cmd_fifo.sv
// Show-ahead synchronous command FIFO; full/empty decoded from a registered occupancy count.
module simd_cmd_fifo
  import fp_simd_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (i_push) begin
      mem_d[wr_q] = i_data;
      wr_d        = wr_q + AW'(1);
    end else begin
      wr_d = wr_q;
    end
    if (i_pop) begin
      rd_d = rd_q + AW'(1);
    end else begin
      rd_d = rd_q;
    end
    case ({i_push, i_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers; reset flushes every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_head  = mem_q[rd_q];
  assign o_full  = (cnt_q == CW'(DEPTH));
  assign o_empty = (cnt_q == CW'(0));

endmodule

// File: rtl/fp_simd_issuer.sv
// Command-side master for the 4-lane FP SIMD ALU: queues commands, issues one at a time
// over en/busy/valid, and returns tagged in-order responses with illegal-op/timeout errors.
module fp_simd_issuer
  import fp_simd_pkg::*;
#(
  parameter int LANES     = SIMD_LANES,
  parameter int FW        = FP_W,
  parameter int CMD_DEPTH = 4,
  parameter int TAG_W     = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [2:0]          i_cmd_opcode,
  input  logic [LANES*FW-1:0] i_cmd_a,
  input  logic [LANES*FW-1:0] i_cmd_b,
  input  logic [TAG_W-1:0]    i_cmd_tag,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [LANES*FW-1:0] o_rsp_data,
  output logic [TAG_W-1:0]    o_rsp_tag,
  output logic                o_rsp_err,
  output logic                o_alu_en,
  output logic [2:0]          o_alu_opcode,
  output logic [LANES*FW-1:0] o_alu_in1,
  output logic [LANES*FW-1:0] o_alu_in2,
  input  logic                i_alu_busy,
  input  logic                i_alu_valid,
  input  logic [LANES*FW-1:0] i_alu_out,
  output logic                o_idle
);

  localparam int VW    = LANES * FW;
  localparam int CW    = 3 + 2 * VW + TAG_W;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMO_LIMIT = TMR_W'(TIMEOUT);

  iss_state_e       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d, timer_inc;
  logic             en_q, en_d;
  logic [2:0]       op_q, op_d;
  logic [VW-1:0]    in1_q, in1_d, in2_q, in2_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [VW-1:0]    rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_err_q, rsp_err_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_head;
  logic [2:0]       head_op;
  logic [VW-1:0]    head_a, head_b;
  logic [TAG_W-1:0] head_tag;

  assign fifo_push = i_cmd_valid & ~fifo_full;
  assign head_op   = fifo_head[CW-1 -: 3];
  assign head_a    = fifo_head[TAG_W + VW +: VW];
  assign head_b    = fifo_head[TAG_W +: VW];
  assign head_tag  = fifo_head[TAG_W-1:0];
  assign timer_inc = timer_q + TMR_W'(1);

  simd_cmd_fifo #(.W(CW), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (fifo_push),
    .i_data  ({i_cmd_opcode, i_cmd_a, i_cmd_b, i_cmd_tag}),
    .i_pop   (fifo_pop),
    .o_head  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Issue FSM, timeout timer and response capture.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    fifo_pop    = 1'b0;
    en_d        = 1'b0;
    op_d        = op_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          if (!op_legal(head_op)) begin
            fifo_pop    = 1'b1;
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_tag_d   = head_tag;
            rsp_err_d   = 1'b1;
          end else if (!i_alu_busy) begin
            state_d = S_ISSUE;
            en_d    = 1'b1;
            op_d    = head_op;
            in1_d   = head_a;
            in2_d   = head_b;
          end else begin
            state_d = S_IDLE;
          end
        // An empty FIFO lets a legal incoming command issue on the very next cycle.
        end else if (fifo_push && op_legal(i_cmd_opcode) && !i_alu_busy) begin
          state_d = S_ISSUE;
          en_d    = 1'b1;
          op_d    = i_cmd_opcode;
          in1_d   = i_cmd_a;
          in2_d   = i_cmd_b;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_alu_valid) begin
          fifo_pop    = 1'b1;
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = i_alu_out;
          rsp_tag_d   = head_tag;
          rsp_err_d   = 1'b0;
          op_d        = 3'd0;
          in1_d       = '0;
          in2_d       = '0;
        end else if (timer_inc == TMO_LIMIT) begin
          fifo_pop    = 1'b1;
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_tag_d   = head_tag;
          rsp_err_d   = 1'b1;
          op_d        = 3'd0;
          in1_d       = '0;
          in2_d       = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, ALU drive and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      en_q        <= 1'b0;
      op_q        <= 3'd0;
      in1_q       <= '0;
      in2_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      en_q        <= en_d;
      op_q        <= op_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign o_cmd_ready  = ~fifo_full;
  assign o_idle       = fifo_empty & (state_q == S_IDLE);
  assign o_alu_en     = en_q;
  assign o_alu_opcode = op_q;
  assign o_alu_in1    = in1_q;
  assign o_alu_in2    = in2_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_data   = rsp_data_q;
  assign o_rsp_tag    = rsp_tag_q;
  assign o_rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_fp_simd_issuer.sv
// Scoreboard bench for fp_simd_issuer with an XOR-result BFM ALU.
module tb_fp_simd_issuer;

  logic        clk;
  logic        rst_n;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [2:0]  i_cmd_opcode;
  logic [87:0] i_cmd_a, i_cmd_b;
  logic [3:0]  i_cmd_tag;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [87:0] o_rsp_data;
  logic [3:0]  o_rsp_tag;
  logic        o_rsp_err;
  logic        o_alu_en;
  logic [2:0]  o_alu_opcode;
  logic [87:0] o_alu_in1, o_alu_in2;
  logic        i_alu_busy, i_alu_valid;
  logic [87:0] i_alu_out;
  logic        o_idle;

  fp_simd_issuer dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_opcode(i_cmd_opcode),
    .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b), .i_cmd_tag(i_cmd_tag),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
    .o_rsp_tag(o_rsp_tag), .o_rsp_err(o_rsp_err),
    .o_alu_en(o_alu_en), .o_alu_opcode(o_alu_opcode), .o_alu_in1(o_alu_in1), .o_alu_in2(o_alu_in2),
    .i_alu_busy(i_alu_busy), .i_alu_valid(i_alu_valid), .i_alu_out(i_alu_out),
    .o_idle(o_idle)
  );

  typedef struct packed {
    logic [3:0]  tag;
    logic        err;
    logic [87:0] data;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, failures = 0;
  int mon_checks = 0, mon_fails = 0;
  int cyc = 0;
  int en_count = 0, en_cyc = -1, v_cyc = -1, rsp_cyc = -1;
  logic rsp_prev = 1'b0;
  int acc_cyc = 0;

  // BFM ALU: busy from en until valid, valid bfm_n cycles after en, result = in1 ^ in2.
  int   bfm_n = 5;
  logic bfm_never = 1'b0, busy_force = 1'b0, force_valid = 1'b0;
  logic bfm_active;
  int   bfm_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bfm_active <= 1'b0;
      bfm_cnt    <= 0;
    end else if (o_alu_en) begin
      bfm_active <= 1'b1;
      bfm_cnt    <= 1;
    end else if (i_alu_valid) begin
      bfm_active <= 1'b0;
      bfm_cnt    <= 0;
    end else if (bfm_active) begin
      bfm_cnt <= bfm_cnt + 1;
    end
  end

  assign i_alu_valid = (bfm_active && bfm_cnt == bfm_n && !bfm_never) || force_valid;
  assign i_alu_busy  = bfm_active || busy_force;
  assign i_alu_out   = o_alu_in1 ^ o_alu_in2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Monitor: event timestamps and in-order response scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_alu_en) begin
        en_count++;
        en_cyc = cyc;
      end
      if (i_alu_valid) v_cyc = cyc;
      if (o_rsp_valid && !rsp_prev) rsp_cyc = cyc;
      rsp_prev = o_rsp_valid;
      if (rst_n && o_rsp_valid && i_rsp_ready) begin
        mon_checks++;
        if (exp_q.size() == 0) begin
          mon_fails++;
          $display("FAIL rsp_unexpected: got tag=%0d err=%0b data=%0h, required no response",
                   o_rsp_tag, o_rsp_err, o_rsp_data);
        end else begin
          e = exp_q.pop_front();
          if ({o_rsp_tag, o_rsp_err, o_rsp_data} !== e) begin
            mon_fails++;
            $display("FAIL rsp: got tag=%0d err=%0b data=%0h, required tag=%0d err=%0b data=%0h",
                     o_rsp_tag, o_rsp_err, o_rsp_data, e.tag, e.err, e.data);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [3:0] tag, input logic err, input logic [87:0] data);
    exp_t e;
    e.tag  = tag;
    e.err  = err;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [2:0] op, input logic [87:0] a, input logic [87:0] b,
                      input logic [3:0] tag);
    logic ok;
    ok           = 1'b0;
    i_cmd_valid  = 1'b1;
    i_cmd_opcode = op;
    i_cmd_a      = a;
    i_cmd_b      = b;
    i_cmd_tag    = tag;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (o_cmd_ready) begin
        acc_cyc = cyc;
        ok      = 1'b1;
        break;
      end
    end
    if (!ok) begin
      failures++;
      $display("FAIL send_accept: tag %0d not accepted within 200 cycles, required accept", tag);
    end
    tick(1);
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check(name, {127'd0, done}, 128'd1);
    tick(2);
  endtask

  initial begin
    logic [21:0] t2_res [6];
    int base, hold_bad, rel;
    logic seen;

    t2_res = '{22'h123FF, 22'h123FE, 22'h123FD, 22'h123FC, 22'h123FB, 22'h123FA};
    rst_n = 1'b0;
    i_cmd_valid = 1'b0; i_cmd_opcode = 3'd0; i_cmd_a = '0; i_cmd_b = '0; i_cmd_tag = 4'd0;
    i_rsp_ready = 1'b1;
    tick(3);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", {127'd0, o_cmd_ready}, 128'd1);
    check("rst_idle", {127'd0, o_idle}, 128'd1);
    check("rst_rsp_valid", {127'd0, o_rsp_valid}, 128'd0);
    check("rst_alu_en", {127'd0, o_alu_en}, 128'd0);
    check("rst_alu_opcode", {125'd0, o_alu_opcode}, 128'd0);
    check("rst_alu_in1", {40'd0, o_alu_in1}, 128'd0);
    check("rst_rsp_data", {40'd0, o_rsp_data}, 128'd0);
    tick(1);

    // 1: single command, latency and operand hold
    bfm_n = 5;
    base  = en_count;
    exp_push(4'd3, 1'b0, {4{22'h0A4C2}});
    send(3'd0, {4{22'h0ABCD}}, {4{22'h00F0F}}, 4'd3);
    hold_bad = 0;
    seen     = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if ({o_alu_opcode, o_alu_in1, o_alu_in2} !== {3'd0, {4{22'h0ABCD}}, {4{22'h00F0F}}})
        hold_bad++;
      if (i_alu_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("t1_valid_seen", {127'd0, seen}, 128'd1);
    check("t1_hold_errors", 128'(hold_bad), 128'd0);
    @(negedge clk);
    check("t1_rsp_at_v_plus_1", {127'd0, o_rsp_valid}, 128'd1);
    check("t1_alu_in1_cleared", {40'd0, o_alu_in1}, 128'd0);
    wait_drain("t1_drain", 50);
    check("t1_en_latency", 128'(en_cyc - acc_cyc), 128'd1);
    check("t1_en_pulses", 128'(en_count - base), 128'd1);

    // 2: back-pressure, 6 commands, response port stalled for 30 cycles
    i_rsp_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          exp_push(4'(k), 1'b0, {4{t2_res[k]}});
          send(3'd1, {4{22'h12300 | 22'(k)}}, {4{22'h000FF}}, 4'(k));
          if (k == 3) begin
            @(negedge clk);
            check("t2_ready_full", {127'd0, o_cmd_ready}, 128'd0);
          end
        end
      end
      begin
        tick(30);
        i_rsp_ready = 1'b1;
      end
    join
    wait_drain("t2_drain", 300);
    check("t2_idle_after", {127'd0, o_idle}, 128'd1);

    // 3: busy gating
    busy_force = 1'b1;
    base = en_count;
    exp_push(4'd7, 1'b0, {4{22'h3FFFF}});
    send(3'd2, {4{22'h2AAAA}}, {4{22'h15555}}, 4'd7);
    tick(10);
    check("t3_no_en_while_busy", 128'(en_count - base), 128'd0);
    busy_force = 1'b0;
    rel = cyc;
    wait_drain("t3_drain", 50);
    check("t3_en_after_busy", 128'(en_cyc - rel), 128'd1);
    check("t3_en_pulses", 128'(en_count - base), 128'd1);

    // 4: illegal opcode followed by a legal one
    base = en_count;
    exp_push(4'd9, 1'b1, 88'd0);
    send(3'd6, {4{22'h3FFFFF}}, {4{22'h00001}}, 4'd9);
    exp_push(4'd10, 1'b0, {4{22'h0A4C2}});
    send(3'd1, {4{22'h0ABCD}}, {4{22'h00F0F}}, 4'd10);
    wait_drain("t4_drain", 50);
    check("t4_en_pulses", 128'(en_count - base), 128'd1);

    // 5: timeout, late valid ignored, next command issued
    bfm_never = 1'b1;
    exp_push(4'd11, 1'b1, 88'd0);
    send(3'd3, {4{22'h01234}}, {4{22'h04321}}, 4'd11);
    wait_drain("t5_drain", 60);
    check("t5_timeout_latency", 128'(rsp_cyc - en_cyc), 128'd16);
    base = en_count;
    force_valid = 1'b1;
    tick(1);
    force_valid = 1'b0;
    bfm_never   = 1'b0;
    tick(5);
    check("t5_late_valid_no_rsp", {127'd0, o_rsp_valid}, 128'd0);
    exp_push(4'd12, 1'b0, {4{22'h05115}});
    send(3'd4, {4{22'h01234}}, {4{22'h04321}}, 4'd12);
    wait_drain("t5_next_drain", 50);
    check("t5_next_en", 128'(en_count - base), 128'd1);

    // 6: reset mid-WAIT with commands queued
    bfm_never = 1'b1;
    send(3'd0, {4{22'h00001}}, {4{22'h00002}}, 4'd1);
    send(3'd0, {4{22'h00003}}, {4{22'h00004}}, 4'd2);
    send(3'd0, {4{22'h00005}}, {4{22'h00006}}, 4'd4);
    tick(4);
    rst_n = 1'b0;
    #2;
    check("t6_rst_cmd_ready", {127'd0, o_cmd_ready}, 128'd1);
    check("t6_rst_idle", {127'd0, o_idle}, 128'd1);
    check("t6_rst_alu_opcode", {125'd0, o_alu_opcode}, 128'd0);
    check("t6_rst_alu_in1", {40'd0, o_alu_in1}, 128'd0);
    tick(2);
    rst_n     = 1'b1;
    bfm_never = 1'b0;
    base      = en_count;
    tick(1);
    force_valid = 1'b1;
    tick(1);
    force_valid = 1'b0;
    tick(8);
    check("t6_no_issue_after_reset", 128'(en_count - base), 128'd0);
    check("t6_no_rsp_after_reset", {127'd0, o_rsp_valid}, 128'd0);
    check("t6_idle_after_reset", {127'd0, o_idle}, 128'd1);

    tick(2);
    checks   += mon_checks;
    failures += mon_fails;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
